// File: rtl/dev_arb_pkg.sv
// Shared types and constants for the three-requester device-bus arbiter.
package dev_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_t;

  localparam int NUM_REQ   = 3;
  localparam int REQ_DATA  = 0;
  localparam int REQ_FETCH = 1;
  localparam int REQ_DMA   = 2;
  localparam int TO_CNT_W  = 8;

  // Requester index addition modulo NUM_REQ; operands are always below NUM_REQ.
  function automatic logic [1:0] idx_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] sum_s;
    sum_s = {1'b0, a} + {1'b0, b};
    if (sum_s >= 3'(NUM_REQ)) begin
      sum_s = sum_s - 3'(NUM_REQ);
    end else begin
      sum_s = sum_s;
    end
    return sum_s[1:0];
  endfunction

endpackage

// File: rtl/dev_arbiter_rr_picker.sv
// Combinational round-robin winner search starting at rr_ptr and wrapping modulo NUM_REQ.
module rr_picker
  import dev_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         rr_ptr,
  output logic               valid,
  output logic [1:0]         idx
);

  logic [1:0] cand_s;

  // Scan from the farthest offset down so the nearest requester to rr_ptr wins.
  always_comb begin
    valid  = 1'b0;
    idx    = 2'd0;
    cand_s = 2'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_s = idx_add(rr_ptr, 2'(k));
      if (req[cand_s]) begin
        valid = 1'b1;
        idx   = cand_s;
      end else begin
        valid = valid;
        idx   = idx;
      end
    end
  end

endmodule

// File: rtl/dev_arbiter.sv
// Round-robin arbiter granting one of three requesters access to a shared device bus.
// Optional busy-timeout abort is enabled by defining DEV_ARB_TIMEOUT_EN.
module dev_arbiter
  import dev_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk25,
  input  logic        rst,
  input  logic [2:0]  req_i,
  input  logic [2:0]  write_i,
  input  logic [95:0] addr_i,
  input  logic [11:0] byteSelect_i,
  input  logic [95:0] dataSave_i,
  output logic [2:0]  done_o,
  output logic        err_o,
  output logic [31:0] dataLoad_o,
  output logic        devEnable_o,
  output logic        devWrite_o,
  output logic [31:0] devPhysicalAddr_o,
  output logic [3:0]  devByteSelect_o,
  output logic [31:0] devDataSave_o,
  input  logic        devBusy_i,
  input  logic [31:0] devDataLoad_i
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2 ** TO_CNT_W) - 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES does not fit the timeout counter");
  end

  arb_state_t  state_r, state_s;
  logic [1:0]  rr_ptr_r, idx_r, pick_idx_s;
  logic        pick_valid_s;
  logic        write_r;
  logic [31:0] addr_r, wdata_r, load_r;
  logic [3:0]  bsel_r;
  logic        sel_write_s;
  logic [31:0] sel_addr_s, sel_wdata_s;
  logic [3:0]  sel_bsel_s;
  logic        grant_s, capture_s, timeout_s, timeout_hit_s, in_access_s;

  rr_picker u_picker (
    .req    (req_i),
    .rr_ptr (rr_ptr_r),
    .valid  (pick_valid_s),
    .idx    (pick_idx_s)
  );

  assign in_access_s = (state_r == ST_ACCESS);

  // Route the winning requester's command fields to the latch inputs.
  always_comb begin
    sel_write_s = 1'b0;
    sel_addr_s  = 32'd0;
    sel_bsel_s  = 4'd0;
    sel_wdata_s = 32'd0;
    case (pick_idx_s)
      2'(REQ_DATA): begin
        sel_write_s = write_i[0];
        sel_addr_s  = addr_i[31:0];
        sel_bsel_s  = byteSelect_i[3:0];
        sel_wdata_s = dataSave_i[31:0];
      end
      2'(REQ_FETCH): begin
        sel_write_s = write_i[1];
        sel_addr_s  = addr_i[63:32];
        sel_bsel_s  = byteSelect_i[7:4];
        sel_wdata_s = dataSave_i[63:32];
      end
      2'(REQ_DMA): begin
        sel_write_s = write_i[2];
        sel_addr_s  = addr_i[95:64];
        sel_bsel_s  = byteSelect_i[11:8];
        sel_wdata_s = dataSave_i[95:64];
      end
      default: begin
        sel_write_s = 1'b0;
        sel_addr_s  = 32'd0;
        sel_bsel_s  = 4'd0;
        sel_wdata_s = 32'd0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk25) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state and per-cycle action strobes.
  always_comb begin
    state_s   = state_r;
    grant_s   = 1'b0;
    capture_s = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          grant_s = 1'b1;
          state_s = ST_ACCESS;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!devBusy_i) begin
          capture_s = 1'b1;
          state_s   = ST_DONE;
        end else if (timeout_hit_s) begin
          timeout_s = 1'b1;
          state_s   = ST_DONE;
        end else begin
          state_s = ST_ACCESS;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Grant latches, read-data capture and round-robin pointer.
  always_ff @(posedge clk25) begin
    if (rst) begin
      rr_ptr_r <= 2'd0;
      idx_r    <= 2'd0;
      write_r  <= 1'b0;
      addr_r   <= 32'd0;
      bsel_r   <= 4'd0;
      wdata_r  <= 32'd0;
      load_r   <= 32'd0;
    end else begin
      if (grant_s) begin
        idx_r   <= pick_idx_s;
        write_r <= sel_write_s;
        addr_r  <= sel_addr_s;
        bsel_r  <= sel_bsel_s;
        wdata_r <= sel_wdata_s;
      end
      if (capture_s) begin
        load_r <= devDataLoad_i;
      end else if (timeout_s) begin
        load_r <= 32'd0;
      end
      if (state_r == ST_DONE) begin
        rr_ptr_r <= idx_add(idx_r, 2'd1);
      end
    end
  end

`ifdef DEV_ARB_TIMEOUT_EN
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);
  logic [TO_CNT_W-1:0] to_cnt_r;
  logic                err_r;

  // The access that would push the counter to TIMEOUT_CYCLES is aborted instead.
  assign timeout_hit_s = (to_cnt_r == TO_LAST);
  assign err_o         = (state_r == ST_DONE) && err_r;

  // Busy-cycle counter and abort flag.
  always_ff @(posedge clk25) begin
    if (rst) begin
      to_cnt_r <= {TO_CNT_W{1'b0}};
      err_r    <= 1'b0;
    end else begin
      if (grant_s) begin
        to_cnt_r <= {TO_CNT_W{1'b0}};
      end else if (in_access_s && devBusy_i) begin
        to_cnt_r <= to_cnt_r + TO_CNT_W'(1);
      end
      if (capture_s) begin
        err_r <= 1'b0;
      end else if (timeout_s) begin
        err_r <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit_s = 1'b0;
  assign err_o         = 1'b0;
`endif

  // Completion pulse to the granted requester.
  always_comb begin
    done_o = 3'b000;
    if (state_r == ST_DONE) begin
      case (idx_r)
        2'd0:    done_o = 3'b001;
        2'd1:    done_o = 3'b010;
        2'd2:    done_o = 3'b100;
        default: done_o = 3'b000;
      endcase
    end else begin
      done_o = 3'b000;
    end
  end

  assign dataLoad_o        = load_r;
  assign devEnable_o       = in_access_s;
  assign devWrite_o        = in_access_s & write_r;
  assign devPhysicalAddr_o = in_access_s ? addr_r  : 32'd0;
  assign devByteSelect_o   = in_access_s ? bsel_r  : 4'd0;
  assign devDataSave_o     = in_access_s ? wdata_r : 32'd0;

endmodule

// File: tb/tb_dev_arbiter.sv
// Randomized self-checking bench for dev_arbiter against a round-robin reference model.
module tb_dev_arbiter;

  logic        clk25 = 1'b0;
  logic        rst;
  logic [2:0]  req_i, write_i;
  logic [95:0] addr_i, dataSave_i;
  logic [11:0] byteSelect_i;
  logic [2:0]  done_o;
  logic        err_o;
  logic [31:0] dataLoad_o;
  logic        devEnable_o, devWrite_o;
  logic [31:0] devPhysicalAddr_o, devDataSave_o;
  logic [3:0]  devByteSelect_o;
  logic        devBusy_i;
  logic [31:0] devDataLoad_i;

  int errors = 0;
  int checks = 0;
  int model_ptr = 0;

  always #20 clk25 = ~clk25;

  dev_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk25(clk25), .rst(rst), .req_i(req_i), .write_i(write_i), .addr_i(addr_i),
    .byteSelect_i(byteSelect_i), .dataSave_i(dataSave_i), .done_o(done_o), .err_o(err_o),
    .dataLoad_o(dataLoad_o), .devEnable_o(devEnable_o), .devWrite_o(devWrite_o),
    .devPhysicalAddr_o(devPhysicalAddr_o), .devByteSelect_o(devByteSelect_o),
    .devDataSave_o(devDataSave_o), .devBusy_i(devBusy_i), .devDataLoad_i(devDataLoad_i)
  );

  // Reference: first requesting index at or after the pointer, wrapping modulo 3.
  function automatic int model_pick(input logic [2:0] req, input int ptr);
    for (int k = 0; k < 3; k++) begin
      if (req[(ptr + k) % 3]) return (ptr + k) % 3;
    end
    return 0;
  endfunction

  task automatic scramble_inputs();
    addr_i       = {$urandom, $urandom, $urandom};
    dataSave_i   = {$urandom, $urandom, $urandom};
    byteSelect_i = 12'($urandom);
    write_i      = 3'($urandom);
  endtask

  // One arbitration: drive req, hold busy for nbusy ACCESS edges, check bus and completion.
  task automatic run_txn(input logic [2:0] req, input int nbusy, input bit hold,
                         input bit keep, output int winner);
    logic [31:0] e_addr, e_data, e_load;
    logic [3:0]  e_bsel;
    logic        e_wr;
    int          acc;
    bit          seen;
    @(negedge clk25);
    checks++;
    if (done_o !== 3'b000) begin
      errors++; $display("FAIL done_width: done_o=%b required 000", done_o);
    end
    if (!keep) scramble_inputs();
    req_i         = req;
    devBusy_i     = 1'b1;
    devDataLoad_i = $urandom;
    winner = model_pick(req, model_ptr);
    e_addr = addr_i[32*winner +: 32];
    e_data = dataSave_i[32*winner +: 32];
    e_bsel = byteSelect_i[4*winner +: 4];
    e_wr   = write_i[winner];
    e_load = 32'd0;
    acc  = 0;
    seen = 1'b0;
    for (int c = 0; c < nbusy + 8 && !seen; c++) begin
      @(negedge clk25);
      if (done_o !== 3'b000) begin
        seen = 1'b1;
        checks++;
        if (done_o !== 3'(1 << winner)) begin
          errors++; $display("FAIL grant: done_o=%b required %b", done_o, 3'(1 << winner));
        end
        checks++;
        if (err_o !== 1'b0 || dataLoad_o !== e_load) begin
          errors++; $display("FAIL load: err_o=%b dataLoad_o=%h required 0/%h", err_o, dataLoad_o, e_load);
        end
        checks++;
        if ({devEnable_o, devWrite_o, devPhysicalAddr_o, devByteSelect_o, devDataSave_o} !== 70'd0) begin
          errors++; $display("FAIL bus_idle: enable=%b addr=%h required all zero", devEnable_o, devPhysicalAddr_o);
        end
      end else if (devEnable_o === 1'b1) begin
        acc++;
        checks++;
        if ({devWrite_o, devPhysicalAddr_o, devByteSelect_o, devDataSave_o} !== {e_wr, e_addr, e_bsel, e_data}) begin
          errors++;
          $display("FAIL bus_cmd: got w=%b a=%h b=%h d=%h required w=%b a=%h b=%h d=%h",
                   devWrite_o, devPhysicalAddr_o, devByteSelect_o, devDataSave_o, e_wr, e_addr, e_bsel, e_data);
        end
        scramble_inputs();
        if (!hold) req_i = 3'($urandom);
        devDataLoad_i = $urandom;
        devBusy_i     = (acc <= nbusy);
        if (!devBusy_i) e_load = devDataLoad_i;
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL no_done: no completion within %0d cycles", nbusy + 8);
    end
    checks++;
    if (acc != nbusy + 1) begin
      errors++; $display("FAIL access_len: %0d ACCESS cycles, required %0d", acc, nbusy + 1);
    end
    if (seen) model_ptr = (winner + 1) % 3;
    if (!hold) req_i = 3'b000;
    devBusy_i = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk25);
    rst = 1'b1;
    @(negedge clk25);
    rst = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_i = 3'b000; devBusy_i = 1'b0; devDataLoad_i = 32'd0;
    scramble_inputs();
    repeat (3) @(negedge clk25);
    checks++;
    if ({done_o, err_o, dataLoad_o, devEnable_o, devWrite_o, devPhysicalAddr_o, devByteSelect_o, devDataSave_o} !== 106'd0) begin
      errors++; $display("FAIL reset_state: done=%b err=%b load=%h en=%b required zeros", done_o, err_o, dataLoad_o, devEnable_o);
    end
    rst = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_single_read();
    int w;
    scramble_inputs();
    addr_i[31:0] = 32'h8000_0010;
    write_i      = 3'b000;
    run_txn(3'b001, 0, 1'b0, 1'b1, w);
  endtask

  task automatic test_contention();
    int w;
    int exp_order[4] = '{0, 1, 2, 0};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      run_txn(3'b111, $urandom_range(0, 2), 1'b1, 1'b0, w);
      checks++;
      if (w != exp_order[i]) begin
        errors++; $display("FAIL rr_order: access %0d model winner %0d required %0d", i, w, exp_order[i]);
      end
    end
    req_i = 3'b000;
  endtask

  task automatic test_busy_stretch();
    int w;
    scramble_inputs();
    write_i = 3'b100;
    run_txn(3'b100, 5, 1'b0, 1'b1, w);
  endtask

  task automatic test_random();
    int w;
    for (int i = 0; i < 24; i++) begin
      run_txn(3'($urandom_range(1, 7)), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, w);
    end
    req_i = 3'b000;
  endtask

  task automatic test_reset_mid_access();
    int  w;
    bit  seen;
    int  pulses;
    run_txn(3'b010, 0, 1'b0, 1'b0, w);
    @(negedge clk25);
    req_i = 3'b100; devBusy_i = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk25);
      seen = (devEnable_o === 1'b1);
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL mid_enter: ACCESS not reached, enable=%b required 1", devEnable_o);
    end
    rst = 1'b1;
    @(negedge clk25);
    checks++;
    if ({done_o, err_o, dataLoad_o, devEnable_o, devPhysicalAddr_o} !== 69'd0) begin
      errors++; $display("FAIL mid_reset: done=%b en=%b load=%h required zeros", done_o, devEnable_o, dataLoad_o);
    end
    rst = 1'b0; req_i = 3'b000; devBusy_i = 1'b0; model_ptr = 0;
    pulses = 0;
    repeat (5) begin
      @(negedge clk25);
      if (done_o !== 3'b000) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL mid_no_done: %0d done pulses after abort, required 0", pulses);
    end
    run_txn(3'b111, 0, 1'b0, 1'b0, w);
  endtask

  task automatic test_timeout();
    int acc;
    int pulses;
    bit seen;
    @(negedge clk25);
    scramble_inputs();
    req_i = 3'b001; devBusy_i = 1'b1; devDataLoad_i = $urandom;
`ifdef DEV_ARB_TIMEOUT_EN
    acc = 0; seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk25);
      if (done_o !== 3'b000) begin
        seen = 1'b1;
        checks++;
        if (done_o !== 3'(1 << model_pick(3'b001, model_ptr)) || err_o !== 1'b1 || dataLoad_o !== 32'd0) begin
          errors++; $display("FAIL timeout_done: done=%b err=%b load=%h required %b/1/0",
                             done_o, err_o, dataLoad_o, 3'(1 << model_pick(3'b001, model_ptr)));
        end
      end else if (devEnable_o === 1'b1) begin
        acc++;
        req_i = 3'b000;
      end
    end
    checks++;
    if (!seen || acc != 16) begin
      errors++; $display("FAIL timeout_len: seen=%0d busy cycles=%0d required 1/16", seen, acc);
    end
`else
    acc = 0; pulses = 0; seen = 1'b0;
    repeat (1000) begin
      @(negedge clk25);
      if (done_o !== 3'b000) pulses++;
      if (devEnable_o === 1'b1) acc++;
      req_i = 3'b000;
    end
    checks++;
    if (pulses != 0 || acc < 998) begin
      errors++; $display("FAIL no_timeout: %0d done pulses, %0d ACCESS cycles, required 0/>=998", pulses, acc);
    end
`endif
    devBusy_i = 1'b0;
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_busy_stretch();
    test_random();
    test_reset_mid_access();
    test_timeout();
    test_single_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
